mem_sram_responder: RTL and testbench

- Memory-side endpoint of the core's memory request/response protocol.
- Accepts `mreq` transactions on a decoupled input and services them from an internal word-addressed SRAM array. Returns exactly one `mtrans` response per request, in order, on a decoupled output.
- Sits behind the core's memory arbiter slave port.
- Used as boot/main memory in simulation and as on-chip RAM in FPGA builds.

---
 rtl/mem_sram_responder_pkg.sv | 29 ++
 rtl/mem_sram_responder_if.sv | 19 +
 rtl/mem_sram_responder_queue.sv | 86 ++++++++
 rtl/mem_sram_responder.sv | 150 +++++++++++++++
 tb/tb_mem_sram_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sram_responder_pkg.sv
// ============================================================================
//  Module   : mem_sram_responder_pkg
//  Brief    : Shared memory-protocol types (mreq / mtrans) and memory base.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_sram_responder_pkg;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        addr_t       addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } mtrans_t;

    // Also used by the core as its boot vector.
    localparam addr_t c_mem_base = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/mem_sram_responder_if.sv
// ============================================================================
//  Module   : mem_sram_responder_if
//  Brief    : Decoupled valid/ready channel carrying a payload of type T.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_sram_responder_if #(
    parameter type T = logic
);
    logic valid;
    logic ready;
    T     data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/mem_sram_responder_queue.sv
// ============================================================================
//  Module   : mem_sram_responder_queue
//  Brief    : DEPTH-entry FIFO; PIPE=1 adds a fall-through bypass when empty.
//             The producer must guarantee free space (no input ready).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_responder_queue #(
    parameter int DEPTH = 2,
    parameter int PIPE  = 1,
    parameter int WIDTH = 33
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic      [WIDTH-1:0] o_data,
    input  wire logic             i_ready
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_w'(DEPTH));

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    generate
        if (PIPE != 0) begin : g_bypass
            assign o_valid = !w_empty || i_valid;
            assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
            assign w_push  = i_valid && !w_full && !(w_empty && i_ready);
            assign w_pop   = !w_empty && i_ready;
        end else begin : g_registered
            assign o_valid = !w_empty;
            assign o_data  = r_mem[r_rd_ptr];
            assign w_push  = i_valid && !w_full;
            assign w_pop   = !w_empty && i_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_sram_responder.sv
// ============================================================================
//  Module   : mem_sram_responder
//  Brief    : SRAM-backed memory endpoint: in-order mreq -> mtrans responses.
//             Define MEM_SRAM_RESPONDER_STALL_EN for LFSR-driven req backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_responder
    import mem_sram_responder_pkg::*;
#(
    parameter int    WORDS       = 4096,
    parameter addr_t BASE        = c_mem_base,
    parameter int    LATENCY     = 1,
    parameter int    OUTSTANDING = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mem_sram_responder_if.slave     req,
    mem_sram_responder_if.master    resp
);

    localparam int          c_idx_w  = $clog2(WORDS);
    localparam int          c_cnt_w  = $clog2(OUTSTANDING + 1);
    localparam logic [32:0] c_span   = 33'(WORDS) * 33'd4;

    mreq_t                 w_req;
    addr_t                 w_off;
    logic                  w_hit;
    logic [c_idx_w-1:0]    w_idx;
    logic                  w_req_fire;
    logic                  w_resp_fire;
    logic                  w_credit;
    logic                  w_stall;

    logic [31:0]           r_mem [WORDS];
    logic [31:0]           r_rd_word;
    logic                  r_s0_vld;
    logic                  r_s0_rd;
    logic                  r_s0_err;
    logic [c_cnt_w-1:0]    r_out_cnt;

    logic    [LATENCY-1:0] w_stage_vld;
    mtrans_t [LATENCY-1:0] w_stage_data;

    assign w_req       = req.data;
    assign w_off       = w_req.addr - BASE;
    assign w_hit       = ({1'b0, w_off} < c_span);
    assign w_idx       = w_off[c_idx_w+1:2];
    assign w_req_fire  = req.valid && req.ready;
    assign w_resp_fire = resp.valid && resp.ready;

    // ---------------- SRAM array (contents survive reset) ----------------
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_rd_word <= r_mem[w_idx];
            if (w_req.we && w_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_req.be[b]) r_mem[w_idx][8*b +: 8] <= w_req.wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- Latency pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_vld <= 1'b0;
            r_s0_rd  <= 1'b0;
            r_s0_err <= 1'b0;
        end else begin
            r_s0_vld <= w_req_fire;
            r_s0_rd  <= w_hit && !w_req.we;
            r_s0_err <= !w_hit;
        end
    end

    assign w_stage_vld[0]       = r_s0_vld;
    assign w_stage_data[0].data = r_s0_rd ? r_rd_word : 32'h0;
    assign w_stage_data[0].err  = r_s0_err;

    generate
        for (genvar s = 1; s < LATENCY; s++) begin : g_stage
            logic    r_vld;
            mtrans_t r_data;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else begin
                    r_vld  <= w_stage_vld[s-1];
                    r_data <= w_stage_data[s-1];
                end
            end
            assign w_stage_vld[s]  = r_vld;
            assign w_stage_data[s] = r_data;
        end
    endgenerate

    // ---------------- Credit counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    assign w_credit = (r_out_cnt < c_cnt_w'(OUTSTANDING));

`ifdef MEM_SRAM_RESPONDER_STALL_EN
    // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
    logic [7:0] r_lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    assign req.ready = !rst && w_credit && !w_stall;

    // ---------------- Response FIFO ----------------
    mem_sram_responder_queue #(
        .DEPTH (OUTSTANDING),
        .PIPE  (1),
        .WIDTH ($bits(mtrans_t))
    ) u_resp_q (
        .clk     (clk),
        .rst     (rst),
        .i_flush (1'b0),
        .i_valid (w_stage_vld[LATENCY-1]),
        .i_data  (w_stage_data[LATENCY-1]),
        .o_valid (resp.valid),
        .o_data  (resp.data),
        .i_ready (resp.ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_responder.sv
// ============================================================================
//  Module   : tb_mem_sram_responder
//  Brief    : Scoreboard bench for mem_sram_responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sram_responder;
    import mem_sram_responder_pkg::*;

    localparam int          WORDS       = 4096;
    localparam int          LATENCY     = 1;
    localparam int          OUTSTANDING = 2;
    localparam logic [31:0] BASE        = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sram_responder_if #(.T(mreq_t))   req_if ();
    mem_sram_responder_if #(.T(mtrans_t)) resp_if ();

    mem_sram_responder #(
        .WORDS       (WORDS),
        .BASE        (BASE),
        .LATENCY     (LATENCY),
        .OUTSTANDING (OUTSTANDING)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req_if),
        .resp (resp_if)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          hs_cyc  = 0;
    logic [31:0] last_rd_data = '0;
    logic [31:0] model_mem [int];
    mtrans_t     exp_q [$];
    mtrans_t     m_e;
    logic        held_v = 1'b0;
    mtrans_t     held_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic mtrans_t model_apply(input mreq_t r);
        logic [31:0] off;
        logic [31:0] w;
        mtrans_t     t;
        int          idx;
        off    = r.addr - BASE;
        t.data = 32'h0;
        t.err  = 1'b0;
        if (64'(off) >= 64'(WORDS) * 64'd4) begin
            t.err = 1'b1;
        end else begin
            idx = int'(off >> 2);
            if (r.we) begin
                w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                for (int b = 0; b < 4; b++) if (r.be[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
                model_mem[idx] = w;
            end else begin
                t.data = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
            end
        end
        return t;
    endfunction

    always @(posedge clk) cyc++;

    // Handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("resp_hold_valid", resp_if.valid, 1'b1);
                chk("resp_hold_data", resp_if.data, held_d);
            end
            if (resp_if.valid && resp_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("resp_data", resp_if.data.data, m_e.data);
                    chk("resp_err", resp_if.data.err, m_e.err);
                end
                last_rd_data = resp_if.data.data;
            end
            if (req_if.valid && req_if.ready) begin
                exp_q.push_back(model_apply(req_if.data));
                hs_cyc = cyc;
            end
            held_v = resp_if.valid && !resp_if.ready;
            held_d = resp_if.data;
        end
    end

    task automatic drive(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd);
        mreq_t r;
        r.addr  = a;
        r.we    = we;
        r.be    = be;
        r.wdata = wd;
        req_if.data = r;
    endtask

    task automatic send(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
        int n = 0;
        drive(a, we, be, wd);
        req_if.valid = 1'b1;
        @(negedge clk);
        while (!req_if.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        req_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk);
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
        #1;
    endtask

    initial begin
        int k, got, it, first_it, last_it, bubbles, n;
        req_if.valid  = 1'b0;
        req_if.data   = '0;
        resp_if.ready = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", req_if.ready, 1'b0);
        chk("rst_resp_valid", resp_if.valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_if.ready, 1'b1);
        @(posedge clk); #1;

        // 1: write then read, check latency
        resp_if.ready = 1'b1;
        send(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        send(BASE + 32'h10, 1'b0, 4'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (!resp_if.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_latency", 64'(cyc - hs_cyc), 64'(LATENCY));
        wait_idle();
        chk("t1_rd_data", last_rd_data, 32'hDEAD_BEEF);

        // 2: byte-enable merge
        send(BASE + 32'h20, 1'b1, 4'hF, 32'h1122_3344);
        send(BASE + 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD);
        send(BASE + 32'h20, 1'b0, 4'h0, 32'h0);
        wait_idle();
        chk("t2_merge", last_rd_data, 32'h11BB_33DD);

        // 3: out-of-range accesses, then an in-range read
        send(32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0);
        send(BASE + WORDS * 4, 1'b0, 4'h0, 32'h0);
        send(BASE - 32'h4, 1'b1, 4'hF, 32'h1234_5678);
        send(BASE + 32'h10, 1'b0, 4'h0, 32'h0);
        wait_idle();
        chk("t3_after_miss", last_rd_data, 32'hDEAD_BEEF);

        for (int i = 0; i < 8; i++) send(BASE + 32'h100 + 4 * i, 1'b1, 4'hF, 32'hA000_0000 + i);
        wait_idle();

        // 4: credit limit under backpressure, then in-order drain
        resp_if.ready = 1'b0;
        k = 0; got = 0; first_it = -1; last_it = -1;
        for (it = 0; it < 40 && got < 4; it++) begin
            if (it == 6) resp_if.ready = 1'b1;
            req_if.valid = (k < 4);
            drive(BASE + 32'h100 + 4 * k, 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            if (it == 5) begin
                chk("t4_accepted", k, OUTSTANDING);
                chk("t4_ready_low", req_if.ready, 1'b0);
            end
            if (resp_if.valid && resp_if.ready) begin
                got++;
                if (got == 1) first_it = it;
                last_it = it;
            end
            if (req_if.valid && req_if.ready) k++;
            @(posedge clk); #1;
        end
        req_if.valid = 1'b0;
        chk("t4_count", got, 4);
        chk("t4_drain_span", 64'(last_it - first_it), 64'd3);
        wait_idle();

        // 5: 100 back-to-back reads
        k = 0; got = 0; bubbles = 0; last_it = -1;
        for (it = 0; it < 400 && got < 100; it++) begin
            req_if.valid = (k < 100);
            drive(BASE + 32'h100 + 4 * (k % 8), 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            if (req_if.valid && !req_if.ready) bubbles++;
            if (resp_if.valid && resp_if.ready) begin
                got++;
                last_it = it;
            end
            if (req_if.valid && req_if.ready) k++;
            @(posedge clk); #1;
        end
        req_if.valid = 1'b0;
        chk("t5_count", got, 100);
        chk("t5_cycles", 64'(last_it + 1), 64'd101);
        chk("t5_bubbles", bubbles, 0);
        wait_idle();

        // 6: reset with responses queued; SRAM contents survive
        send(BASE + 32'h40, 1'b1, 4'hF, 32'hCAFE_F00D);
        wait_idle();
        resp_if.ready = 1'b0;
        send(BASE + 32'h40, 1'b0, 4'h0, 32'h0);
        send(BASE + 32'h100, 1'b0, 4'h0, 32'h0);
        @(posedge clk); #1;
        chk("t6_cnt_before", dut.r_out_cnt, 2);
        chk("t6_valid_before", resp_if.valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_resp_valid", resp_if.valid, 1'b0);
        chk("t6_rst_req_ready", req_if.ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_cnt_after", dut.r_out_cnt, 0);
        chk("t6_req_ready", req_if.ready, 1'b1);
        chk("t6_resp_valid", resp_if.valid, 1'b0);
        @(posedge clk); #1;
        resp_if.ready = 1'b1;
        send(BASE + 32'h40, 1'b0, 4'h0, 32'h0);
        wait_idle();
        chk("t6_retained", last_rd_data, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
